// File: rtl/lsu_pkg.sv
// Shared definitions for the load-store unit.
//   - slt_sl_e   : size/sign select codes driven by the control unit
//   - *_BASE     : word-aligned base addresses of the memory-mapped peripherals
//   - HEX_OFF    : 7-segment pattern with every segment dark (active-low)
package lsu_pkg;

    typedef enum logic [2:0] {
        SB  = 3'b000,
        SH  = 3'b001,
        SW  = 3'b010,
        LB  = 3'b011,
        LH  = 3'b100,
        LW  = 3'b101,
        LBU = 3'b110,
        LHU = 3'b111
    } slt_sl_e;

    localparam logic [31:0] LEDR_BASE  = 32'h1000_0000;
    localparam logic [31:0] LEDG_BASE  = 32'h1000_1000;
    localparam logic [31:0] HEX0_BASE  = 32'h1000_2000;
    localparam logic [31:0] HEX4_BASE  = 32'h1000_2004;
    localparam logic [31:0] LCD_BASE   = 32'h1000_3000;
    localparam logic [31:0] TIMER_BASE = 32'h1000_4000;
    localparam logic [31:0] SW_BASE    = 32'h1001_0000;
    localparam logic [31:0] BTN_BASE   = 32'h1001_1000;

    localparam logic [6:0] HEX_OFF = 7'h7F;

endpackage

// File: rtl/lsu_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Ports:
//   i_clk   : destination clock
//   i_reset : asynchronous active-high reset, clears both stages to 0
//   i_d     : asynchronous input bus
//   o_q     : synchronised output, two edges behind i_d
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/lsu.sv
// Load-store unit: data memory, memory-mapped I/O registers, free-running timer
// and input synchronisers for the single-cycle RV32I core.
// Ports:
//   i_clk, i_reset      : core clock, asynchronous active-high reset
//   i_lsu_addr          : byte address from the ALU
//   i_st_data           : store data (rs2)
//   i_lsu_wren          : store enable
//   i_slt_sl            : size/sign select (see lsu_pkg::slt_sl_e)
//   i_io_sw, i_io_btn   : asynchronous switch / button inputs
//   o_ld_data           : combinational load result
//   o_io_ledr/ledg/lcd  : peripheral registers
//   o_io_hex            : eight active-low 7-seg digits, digit n on [7n+6:7n]
//   o_misaligned        : only when LSU_MISALIGN_EN is defined; flags misaligned
//                         half/word accesses, which suppress the store and zero the load
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_ADDR_W = 11
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lsu_addr,
    input  logic [31:0] i_st_data,
    input  logic        i_lsu_wren,
    input  logic [2:0]  i_slt_sl,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn,
    output logic [31:0] o_ld_data,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [55:0] o_io_hex,
    output logic [31:0] o_io_lcd
`ifdef LSU_MISALIGN_EN
    ,
    output logic        o_misaligned
`endif
);

    localparam int unsigned DMEM_WORDS = 2 ** (DMEM_ADDR_W - 2);
    localparam logic [31:0] HEX_RESET  = {4{1'b0, HEX_OFF}};

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w,
                                             input slt_sl_e     sl,
                                             input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        unique case (sl)
            LB:      res = {{24{b[7]}}, b};
            LBU:     res = {24'h0, b};
            LH:      res = {{16{h[15]}}, h};
            LHU:     res = {16'h0, h};
            default: res = w;  // lw and non-load cycles return the aligned word
        endcase
        return res;
    endfunction

    slt_sl_e     slt_sl;
    logic [31:0] word_addr;
    logic        sel_dmem;
    logic        is_store_code;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic        misaligned;
    logic        st_en;
    logic [31:0] rd_word;
    logic [31:0] sw_sync;
    logic [3:0]  btn_sync;

    logic [31:0] ledr_q, ledr_d;
    logic [31:0] ledg_q, ledg_d;
    logic [31:0] hex_lo_q, hex_lo_d;
    logic [31:0] hex_hi_q, hex_hi_d;
    logic [31:0] lcd_q, lcd_d;
    logic [31:0] timer_q, timer_d;

    logic [31:0]            dmem [DMEM_WORDS];
    logic [DMEM_ADDR_W-3:0] dmem_idx;
    logic                   dmem_we;
    logic [31:0]            dmem_wdata;

    assign slt_sl    = slt_sl_e'(i_slt_sl);
    assign word_addr = {i_lsu_addr[31:2], 2'b00};
    assign sel_dmem  = (i_lsu_addr[31:DMEM_ADDR_W] == '0);
    assign dmem_idx  = i_lsu_addr[DMEM_ADDR_W-1:2];

    // Store lane enables and lane-replicated data.
    always_comb begin
        is_store_code = 1'b0;
        st_be         = 4'b0000;
        st_wdata      = i_st_data;
        unique case (slt_sl)
            SB: begin
                is_store_code = 1'b1;
                st_be         = 4'b0001 << i_lsu_addr[1:0];
                st_wdata      = {4{i_st_data[7:0]}};
            end
            SH: begin
                is_store_code = 1'b1;
                st_be         = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata      = {2{i_st_data[15:0]}};
            end
            SW: begin
                is_store_code = 1'b1;
                st_be         = 4'b1111;
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_EN
    always_comb begin
        misaligned = 1'b0;
        unique case (slt_sl)
            SH, LH, LHU: misaligned = i_lsu_addr[0];
            SW, LW:      misaligned = (i_lsu_addr[1:0] != 2'b00);
            default:     ;
        endcase
        // A store code without write enable is not an access at all.
        if (is_store_code && !i_lsu_wren) begin
            misaligned = 1'b0;
        end
    end
    assign o_misaligned = misaligned;
`else
    assign misaligned = 1'b0;
`endif

    assign st_en = i_lsu_wren & is_store_code & ~misaligned;

    // Read mux sees pre-edge state, giving read-before-write on the same address.
    always_comb begin
        rd_word = 32'h0;
        if (sel_dmem) begin
            rd_word = dmem[dmem_idx];
        end else begin
            unique case (word_addr)
                LEDR_BASE:  rd_word = ledr_q;
                LEDG_BASE:  rd_word = ledg_q;
                HEX0_BASE:  rd_word = hex_lo_q;
                HEX4_BASE:  rd_word = hex_hi_q;
                LCD_BASE:   rd_word = lcd_q;
                TIMER_BASE: rd_word = timer_q;
                SW_BASE:    rd_word = sw_sync;
                BTN_BASE:   rd_word = {28'h0, btn_sync};
                default:    rd_word = 32'h0;
            endcase
        end
    end

    assign o_ld_data = misaligned ? 32'h0 : load_ext(rd_word, slt_sl, i_lsu_addr[1:0]);

    always_comb begin
        ledr_d   = ledr_q;
        ledg_d   = ledg_q;
        hex_lo_d = hex_lo_q;
        hex_hi_d = hex_hi_q;
        lcd_d    = lcd_q;
        timer_d  = timer_q + 32'd1;
        if (st_en && !sel_dmem) begin
            unique case (word_addr)
                LEDR_BASE:  ledr_d   = merge_lanes(ledr_q, st_wdata, st_be);
                LEDG_BASE:  ledg_d   = merge_lanes(ledg_q, st_wdata, st_be);
                // Bit 7 of each lane has no segment; keep it 0 so reads show 0.
                HEX0_BASE:  hex_lo_d = merge_lanes(hex_lo_q, st_wdata, st_be) & HEX_RESET;
                HEX4_BASE:  hex_hi_d = merge_lanes(hex_hi_q, st_wdata, st_be) & HEX_RESET;
                LCD_BASE:   lcd_d    = merge_lanes(lcd_q, st_wdata, st_be);
                TIMER_BASE: timer_d  = merge_lanes(timer_q, st_wdata, st_be);
                default:    ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ledr_q   <= 32'h0;
            ledg_q   <= 32'h0;
            hex_lo_q <= HEX_RESET;
            hex_hi_q <= HEX_RESET;
            lcd_q    <= 32'h0;
            timer_q  <= 32'h0;
        end else begin
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            hex_lo_q <= hex_lo_d;
            hex_hi_q <= hex_hi_d;
            lcd_q    <= lcd_d;
            timer_q  <= timer_d;
        end
    end

    // DMEM has no reset; a store coinciding with reset is dropped.
    assign dmem_we    = st_en & sel_dmem & ~i_reset;
    assign dmem_wdata = merge_lanes(dmem[dmem_idx], st_wdata, st_be);

    always_ff @(posedge i_clk) begin
        if (dmem_we) begin
            dmem[dmem_idx] <= dmem_wdata;
        end
    end

    sync_2ff #(
        .WIDTH (32)
    ) u_sync_sw (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_io_sw),
        .o_q     (sw_sync)
    );

    sync_2ff #(
        .WIDTH (4)
    ) u_sync_btn (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_io_btn),
        .o_q     (btn_sync)
    );

    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex  = {hex_hi_q[30:24], hex_hi_q[22:16], hex_hi_q[14:8], hex_hi_q[6:0],
                        hex_lo_q[30:24], hex_lo_q[22:16], hex_lo_q[14:8], hex_lo_q[6:0]};

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed steps followed by randomized traffic
// compared against a byte-level behavioural model of the address map.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        wren;
    logic [2:0]  sl;
    logic [31:0] io_sw;
    logic [3:0]  io_btn;
    logic [31:0] ld_data;
    logic [31:0] io_ledr;
    logic [31:0] io_ledg;
    logic [55:0] io_hex;
    logic [31:0] io_lcd;
`ifdef LSU_MISALIGN_EN
    logic        misaligned;
`endif

    always #5 clk = ~clk;

    lsu dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_lsu_addr (addr),
        .i_st_data  (st_data),
        .i_lsu_wren (wren),
        .i_slt_sl   (sl),
        .i_io_sw    (io_sw),
        .i_io_btn   (io_btn),
        .o_ld_data  (ld_data),
        .o_io_ledr  (io_ledr),
        .o_io_ledg  (io_ledg),
        .o_io_hex   (io_hex),
        .o_io_lcd   (io_lcd)
`ifdef LSU_MISALIGN_EN
        ,
        .o_misaligned (misaligned)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state.
    logic [7:0]  mem_m [0:2047];
    logic [31:0] ledr_m, ledg_m, hex_lo_m, hex_hi_m, lcd_m, tm_m;
    bit          tm_wr;
    logic [31:0] sw_h[$];
    logic [3:0]  btn_h[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] s);
        case (s)
            3'd0, 3'd3, 3'd6: return 1;
            3'd1, 3'd4, 3'd7: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [2:0] s, input logic we);
`ifdef LSU_MISALIGN_EN
        if (s <= 3'd2 && !we) return 1'b0;
        return (int'(a[1:0]) % size_of(s)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        ledr_m   = 0;
        ledg_m   = 0;
        lcd_m    = 0;
        tm_m     = 0;
        hex_lo_m = 32'h7F7F_7F7F;
        hex_hi_m = 32'h7F7F_7F7F;
        sw_h     = '{32'h0, 32'h0};
        btn_h    = '{4'h0, 4'h0};
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w < 32'd2048) return {mem_m[w+3], mem_m[w+2], mem_m[w+1], mem_m[w]};
        case (w)
            32'h1000_0000: return ledr_m;
            32'h1000_1000: return ledg_m;
            32'h1000_2000: return hex_lo_m;
            32'h1000_2004: return hex_hi_m;
            32'h1000_3000: return lcd_m;
            32'h1000_4000: return tm_m;
            32'h1001_0000: return sw_h[0];
            32'h1001_1000: return {28'h0, btn_h[0]};
            default:       return 32'h0;
        endcase
    endfunction

    task automatic write_byte(input logic [31:0] ba, input logic [7:0] b);
        logic [31:0] w;
        int          ln;
        w  = {ba[31:2], 2'b00};
        ln = int'(ba[1:0]);
        if (w < 32'd2048) begin
            mem_m[ba] = b;
        end else begin
            case (w)
                32'h1000_0000: ledr_m[8*ln +: 8] = b;
                32'h1000_1000: ledg_m[8*ln +: 8] = b;
                32'h1000_2000: hex_lo_m[8*ln +: 8] = {1'b0, b[6:0]};
                32'h1000_2004: hex_hi_m[8*ln +: 8] = {1'b0, b[6:0]};
                32'h1000_3000: lcd_m[8*ln +: 8] = b;
                32'h1000_4000: begin
                    tm_m[8*ln +: 8] = b;
                    tm_wr = 1'b1;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] s,
                                               input logic we);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        if (model_mis(a, s, we)) return 32'h0;
        w = model_word(a);
        b = w[8*int'(a[1:0]) +: 8];
        h = w[16*int'(a[1]) +: 16];
        case (s)
            3'd3:    return {{24{b[7]}}, b};
            3'd4:    return {{16{h[15]}}, h};
            3'd6:    return {24'h0, b};
            3'd7:    return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [55:0] model_hex();
        logic [55:0] r;
        for (int n = 0; n < 8; n++) begin
            r[7*n +: 7] = (n < 4) ? hex_lo_m[8*n +: 7] : hex_hi_m[8*(n-4) +: 7];
        end
        return r;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [2:0] s, input logic we,
                         input logic [31:0] d);
        addr    = a;
        sl      = s;
        wren    = we;
        st_data = d;
        #1;
    endtask

    // Advance one edge, updating the model from the inputs presented before it.
    task automatic tick();
        int          n;
        logic [31:0] base;
        tm_wr = 1'b0;
        if (wren && sl <= 3'd2 && !model_mis(addr, sl, wren)) begin
            n    = size_of(sl);
            base = addr - (addr % n);
            for (int i = 0; i < n; i++) write_byte(base + i, st_data[8*i +: 8]);
        end
        if (!tm_wr) tm_m = tm_m + 1;
        sw_h.push_back(io_sw);
        void'(sw_h.pop_front());
        btn_h.push_back(io_btn);
        void'(btn_h.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ledr"}, {32'h0, io_ledr}, {32'h0, ledr_m});
        check({tag, ".ledg"}, {32'h0, io_ledg}, {32'h0, ledg_m});
        check({tag, ".lcd"}, {32'h0, io_lcd}, {32'h0, lcd_m});
        check({tag, ".hex"}, {8'h0, io_hex}, {8'h0, model_hex()});
    endtask

    task automatic load_chk(input string tag, input logic [31:0] a, input logic [2:0] s,
                            input logic [31:0] exp);
        drive(a, s, 1'b0, 32'h0);
        check(tag, {32'h0, ld_data}, {32'h0, exp});
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rs;
        logic        rw;
        logic [31:0] rd;

        rst    = 1'b1;
        io_sw  = 32'h0;
        io_btn = 4'h0;
        drive(32'h0, 3'd5, 1'b0, 32'h0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state.
        check("rst.hex", {8'h0, io_hex}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
        load_chk("rst.ledr", 32'h1000_0000, 3'd5, 32'h0);
        load_chk("rst.ledg", 32'h1000_1000, 3'd5, 32'h0);
        load_chk("rst.lcd", 32'h1000_3000, 3'd5, 32'h0);
        load_chk("rst.timer", 32'h1000_4000, 3'd5, 32'h0);
        load_chk("rst.hexrd", 32'h1000_2000, 3'd5, 32'h7F7F_7F7F);

        // Byte store into HEX digit 1.
        drive(32'h1000_2001, 3'd0, 1'b1, 32'h0000_005A);
        tick();
        check("sb.hex1", {57'h0, io_hex[13:7]}, {57'h0, 7'h5A});
        check("sb.hex0", {57'h0, io_hex[6:0]}, {57'h0, 7'h7F});
        check("sb.hexhi", {22'h0, io_hex[55:14]}, {22'h0, 42'h3FF_FFFF_FFFF});

        // Half store into upper LEDR lanes.
        drive(32'h1000_0002, 3'd1, 1'b1, 32'hFFFF_1234);
        tick();
        check("sh.ledr", {32'h0, io_ledr}, {32'h0, 32'h1234_0000});
        check_outputs("sh");

        // Word store then every load flavour.
        drive(32'h0000_0100, 3'd2, 1'b1, 32'h8899_AABB);
        tick();
        load_chk("lb.100", 32'h100, 3'd3, 32'hFFFF_FFBB);
        load_chk("lbu.101", 32'h101, 3'd6, 32'h0000_00AA);
        load_chk("lh.102", 32'h102, 3'd4, 32'hFFFF_8899);
        load_chk("lhu.100", 32'h100, 3'd7, 32'h0000_AABB);
        load_chk("lw.100", 32'h100, 3'd5, 32'h8899_AABB);
        load_chk("lb.103", 32'h103, 3'd3, 32'hFFFF_FF88);

        // Read-during-write returns the pre-edge word.
        drive(32'h0000_0100, 3'd0, 1'b1, 32'h0000_0011);
        check("rdw.pre", {32'h0, ld_data}, {32'h0, 32'h8899_AABB});
        tick();
        load_chk("rdw.post", 32'h100, 3'd5, 32'h8899_AA11);

        // Switch synchroniser latency.
        io_sw = 32'h1234_5678;
        drive(32'h1001_0000, 3'd5, 1'b0, 32'h0);
        tick();
        tick();
        tick();
        io_sw = 32'hDEAD_BEEF;
        load_chk("sync.pre", 32'h1001_0000, 3'd5, 32'h1234_5678);
        tick();
        load_chk("sync.e1", 32'h1001_0000, 3'd5, 32'h1234_5678);
        tick();
        load_chk("sync.e2", 32'h1001_0000, 3'd5, 32'hDEAD_BEEF);
        io_btn = 4'hA;
        tick();
        tick();
        load_chk("btn", 32'h1001_1000, 3'd5, 32'h0000_000A);

        // Timer load and wrap.
        drive(32'h1000_4000, 3'd2, 1'b1, 32'hFFFF_FFFE);
        tick();
        load_chk("tmr.0", 32'h1000_4000, 3'd5, 32'hFFFF_FFFE);
        tick();
        load_chk("tmr.1", 32'h1000_4000, 3'd5, 32'hFFFF_FFFF);
        tick();
        load_chk("tmr.2", 32'h1000_4000, 3'd5, 32'h0000_0000);

        // Unmapped store and load.
        drive(32'h2000_0000, 3'd2, 1'b1, 32'h5555_5555);
        tick();
        check_outputs("unmap");
        load_chk("unmap.ld", 32'h2000_0000, 3'd5, 32'h0);
        load_chk("unmap.gap", 32'h1000_0004, 3'd5, 32'h0);

`ifdef LSU_MISALIGN_EN
        drive(32'h0000_0102, 3'd2, 1'b1, 32'h0000_0001);
        check("mis.sw", {63'h0, misaligned}, 64'h1);
        tick();
        load_chk("mis.keep", 32'h100, 3'd5, 32'h8899_AA11);
        drive(32'h0000_0101, 3'd4, 1'b0, 32'h0);
        check("mis.lh", {63'h0, misaligned}, 64'h1);
        check("mis.ld0", {32'h0, ld_data}, 64'h0);
`endif

        // Prefill a small DMEM window for randomized traffic.
        for (int i = 0; i < 16; i++) begin
            drive(32'(i * 4), 3'd2, 1'b1, $urandom);
            tick();
        end

        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 10))
                0, 1, 2: ra = 32'($urandom_range(0, 63));
                3:       ra = 32'h1000_0000;
                4:       ra = 32'h1000_1000;
                5:       ra = 32'h1000_2000;
                6:       ra = 32'h1000_2004;
                7:       ra = 32'h1000_3000;
                8:       ra = 32'h1000_4000;
                9:       ra = ($urandom_range(0, 1) == 1) ? 32'h1001_0000 : 32'h1001_1000;
                default: ra = 32'h3000_0000;
            endcase
            if (ra >= 32'h1000_0000) ra = ra + 32'($urandom_range(0, 3));
            rs = 3'($urandom_range(0, 7));
            rw = 1'($urandom_range(0, 1));
            rd = $urandom;
            if ($urandom_range(0, 7) == 0) io_sw = $urandom;
            if ($urandom_range(0, 7) == 0) io_btn = 4'($urandom);
            drive(ra, rs, rw, rd);
            check("rnd.ld", {32'h0, ld_data}, {32'h0, model_load(ra, rs, rw)});
            tick();
            check_outputs("rnd");
        end

        // Reset mid-operation drops the pending store and clears registers.
        drive(32'h1000_0000, 3'd2, 1'b1, 32'hCAFE_F00D);
        rst = 1'b1;
        #1;
        check("mrst.ledr", {32'h0, io_ledr}, 64'h0);
        check("mrst.hex", {8'h0, io_hex}, {8'h0, 56'hFF_FFFF_FFFF_FFFF});
        @(posedge clk);
        #1;
        check("mrst.hold", {32'h0, io_ledr}, 64'h0);
        wren = 1'b0;
        model_reset();
        rst = 1'b0;
        #1;
        load_chk("mrst.tmr", 32'h1000_4000, 3'd5, 32'h0);
        tick();
        load_chk("mrst.tmr1", 32'h1000_4000, 3'd5, 32'h1);
        check_outputs("mrst");
        load_chk("mrst.dmem", 32'h100, 3'd5, 32'h8899_AA11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
